// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared multi-driven bus.
// One driver is granted at a time. A tenure is bounded by MAX_HOLD cycles.
// Every handover passes through TA_CYCLES cycles in which no driver is enabled.
module tri_bus_arbiter #(
    parameter  int N_REQ     = 4,
    parameter  int MAX_HOLD  = 8,
    parameter  int TA_CYCLES = 1,
    localparam int OW        = (N_REQ > 2) ? $clog2(N_REQ) : 1,
    localparam int HW        = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             drv_en,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic             hold_timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    localparam logic [HW-1:0]    HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [2:0]       TA_INIT  = 3'(TA_CYCLES);
    localparam logic [OW-1:0]    LAST     = OW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state, nstate;
    logic [N_REQ-1:0] ngnt;
    logic [OW-1:0]    ptr, nptr, nowner, win, idx;
    logic [HW-1:0]    hold_cnt, nhold;
    logic [2:0]       ta_cnt, nta;
    logic             nto, rel, lim;

    // Rotating priority scan: the lowest offset from ptr with req set wins.
    // Scanning from the far end lets the nearest hit overwrite the rest.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = OW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) win = idx;
        end
    end

    // Next-state logic for the state machine, grant, pointer and counters.
    always_comb begin
        nstate = state;
        ngnt   = gnt;
        nowner = owner;
        nptr   = ptr;
        nhold  = hold_cnt;
        nta    = ta_cnt;
        nto    = 1'b0;
        rel    = done[owner] | ~req[owner];
        lim    = (hold_cnt == HOLD_MAX);
        case (state)
            IDLE: begin
                if (|req) begin
                    nstate = GRANT;
                    ngnt   = ONE << win;
                    nowner = win;
                    nhold  = HW'(1);
                end
            end
            GRANT: begin
                if (rel || lim) begin
                    // A timeout is reported only when the hold limit is the sole cause.
                    nstate = TURN;
                    ngnt   = '0;
                    nptr   = (owner == LAST) ? '0 : owner + 1'b1;
                    nta    = TA_INIT;
                    nhold  = '0;
                    nto    = lim & ~rel;
                end else begin
                    nhold  = lim ? hold_cnt : hold_cnt + 1'b1;
                end
            end
            TURN: begin
                nta = ta_cnt - 1'b1;
                if (ta_cnt == 3'd1) begin
                    // Last gap cycle: arbitrate with the already advanced pointer.
                    if (|req) begin
                        nstate = GRANT;
                        ngnt   = ONE << win;
                        nowner = win;
                        nhold  = HW'(1);
                    end else begin
                        nstate = IDLE;
                    end
                end
            end
            default: begin
                nstate = IDLE;
                ngnt   = '0;
            end
        endcase
    end

    // State and output registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gnt          <= '0;
            owner        <= '0;
            ptr          <= '0;
            hold_cnt     <= '0;
            ta_cnt       <= '0;
            hold_timeout <= 1'b0;
        end else begin
            state        <= nstate;
            gnt          <= ngnt;
            owner        <= nowner;
            ptr          <= nptr;
            hold_cnt     <= nhold;
            ta_cnt       <= nta;
            hold_timeout <= nto;
        end
    end

    assign drv_en = |gnt;
    assign busy   = (state != IDLE);

endmodule
